sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds a non-power-of-two depth, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, an underflow flag and a read-data valid strobe. It sits between any producer/consumer pair in the same clock domain and is the default buffering primitive for new datapath blocks.

---
 rtl/sync_fifo_ext.sv | 216 +++++++++++++++++++++
 tb/tb_sync_fifo_ext.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ext
// Description : Single-clock FIFO with arbitrary (non power-of-two) depth,
//               programmable almost-full/almost-empty thresholds, standard or
//               first-word-fall-through read mode, overflow/underflow flags
//               and a read-data valid indication.
//               Optional build macro SYNC_FIFO_STICKY_ERR_EN: when defined,
//               overflow/underflow latch until aclr_n or sclr_n; otherwise
//               they pulse for one cycle per rejected request.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         sclr_n,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         valid,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   usedw
);

  localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_USED_W = $clog2(DEPTH + 1);

  localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_USED_W-1:0] c_USED_MAX = c_USED_W'(DEPTH);
  localparam logic [c_USED_W-1:0] c_AF_LVL   = c_USED_W'(AF_THRESH);
  localparam logic [c_USED_W-1:0] c_AE_LVL   = c_USED_W'(AE_THRESH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality checks
  // --------------------------------------------------------------------------
  generate
    if (DATA_WIDTH < 1) begin : g_chk_data_width
      $error("sync_fifo_ext: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_chk_depth
      $error("sync_fifo_ext: DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_chk_af
      $error("sync_fifo_ext: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_chk_ae
      $error("sync_fifo_ext: AE_THRESH must be in 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_chk_fwft
      $error("sync_fifo_ext: FWFT must be 0 or 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_USED_W-1:0]   r_usedw;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_allow;
  logic                  w_wr_allow;
  logic                  w_wr_do;
  logic [c_USED_W-1:0]   w_usedw_next;
  logic                  w_ovf_next;
  logic                  w_udf_next;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [c_PTR_W-1:0]    w_wr_ptr_inc;
  logic [c_PTR_W-1:0]    w_rd_ptr_inc;
  logic [DATA_WIDTH-1:0] w_head;

  // A read is only honoured when data is present; a write into a full FIFO
  // is honoured when a read frees a slot in the same cycle.
  assign w_rd_allow = rd_en & ~r_empty;
  assign w_wr_allow = wr_en & (~r_full | w_rd_allow);
  // Synchronous clear suppresses the storage write as well.
  assign w_wr_do    = w_wr_allow & sclr_n;

  assign w_ovf_next = wr_en & ~w_wr_allow;
  assign w_udf_next = rd_en & r_empty;

`ifdef SYNC_FIFO_STICKY_ERR_EN
  assign w_ovf_set = r_overflow  | w_ovf_next;
  assign w_udf_set = r_underflow | w_udf_next;
`else
  assign w_ovf_set = w_ovf_next;
  assign w_udf_set = w_udf_next;
`endif

  // Pointers wrap by explicit compare so any DEPTH works.
  assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

  assign w_head = r_mem[r_rd_ptr];

  // Occupancy for the next cycle: +1 write only, -1 read only.
  always_comb begin
    w_usedw_next = r_usedw;
    if (w_wr_allow && !w_rd_allow) begin
      w_usedw_next = r_usedw + 1'b1;
    end else if (!w_wr_allow && w_rd_allow) begin
      w_usedw_next = r_usedw - 1'b1;
    end
  end

  // Storage array: never cleared, only written on an accepted write.
  always_ff @(posedge clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered status/error flags.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_usedw        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (!sclr_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_usedw        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_allow) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_rd_allow) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_usedw        <= w_usedw_next;
      r_full         <= (w_usedw_next == c_USED_MAX);
      r_almost_full  <= (w_usedw_next >= c_AF_LVL);
      r_empty        <= (w_usedw_next == '0);
      r_almost_empty <= (w_usedw_next <= c_AE_LVL);
      r_overflow     <= w_ovf_set;
      r_underflow    <= w_udf_set;
    end
  end

  // --------------------------------------------------------------------------
  // Read-side presentation
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown as soon as it exists; zero while empty so the
      // cleared state presents dout=0.
      assign dout  = r_empty ? '0 : w_head;
      assign valid = ~r_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_valid;

      // Registered read: an accepted read loads dout and strobes valid once.
      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else if (!sclr_n) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else if (w_rd_allow) begin
          r_dout  <= w_head;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end

      assign dout  = r_dout;
      assign valid = r_valid;
    end
  endgenerate

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign usedw        = r_usedw;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ext
// Description : Scoreboard bench for sync_fifo_ext. A DEPTH=5 standard-mode
//               instance is driven by directed vectors while a monitor pops
//               expected read data on every valid strobe; a second DEPTH=5
//               FWFT instance is exercised with direct checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sync_fifo_ext;

  localparam int c_DW    = 8;
  localparam int c_DEPTH = 5;
  localparam int c_AF    = 3;
  localparam int c_AE    = 2;
  localparam int c_UW    = $clog2(c_DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            aclr_n;
  logic            sclr_n;

  // standard-mode instance
  logic [c_DW-1:0] din;
  logic            wr_en;
  logic            rd_en;
  logic [c_DW-1:0] dout;
  logic            valid, full, almost_full, empty, almost_empty;
  logic            overflow, underflow;
  logic [c_UW-1:0] usedw;

  // FWFT instance
  logic [c_DW-1:0] f_din;
  logic            f_wr_en;
  logic            f_rd_en;
  logic [c_DW-1:0] f_dout;
  logic            f_valid, f_full, f_almost_full, f_empty, f_almost_empty;
  logic            f_overflow, f_underflow;
  logic [c_UW-1:0] f_usedw;

  int n_cmp = 0;
  int n_bad = 0;

  logic [c_DW-1:0] sb[$];   // expected read data, in order
  logic [c_DW-1:0] mq[$];   // reference FIFO contents
  bit              m_ovf;
  bit              m_udf;

  sync_fifo_ext #(
    .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH), .AF_THRESH(c_AF),
    .AE_THRESH(c_AE), .FWFT(0)
  ) u_dut (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .dout(dout), .valid(valid),
    .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .usedw(usedw)
  );

  sync_fifo_ext #(
    .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH), .AF_THRESH(c_AF),
    .AE_THRESH(c_AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(f_din),
    .wr_en(f_wr_en), .rd_en(f_rd_en), .dout(f_dout), .valid(f_valid),
    .full(f_full), .almost_full(f_almost_full), .empty(f_empty),
    .almost_empty(f_almost_empty), .overflow(f_overflow),
    .underflow(f_underflow), .usedw(f_usedw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid strobe must match the next expected word.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rd_data: got %0h with valid, expected no read", dout);
      end else begin
        logic [c_DW-1:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %0h expected %0h at %0t", dout, e, $time);
        end
      end
    end
  end

  task automatic check_status();
    chk("usedw",        32'(usedw),        32'(mq.size()));
    chk("full",         32'(full),         32'(mq.size() == c_DEPTH));
    chk("empty",        32'(empty),        32'(mq.size() == 0));
    chk("almost_full",  32'(almost_full),  32'(mq.size() >= c_AF));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= c_AE));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
  endtask

  // One clock of stimulus on the standard instance; called at posedge+1.
  task automatic cyc(input bit we, input bit re, input logic [c_DW-1:0] d, input bit sc);
    bit rd_ok, wr_ok, ovf_p, udf_p;
    if (sc) begin
      rd_ok = 0; wr_ok = 0; ovf_p = 0; udf_p = 0;
    end else begin
      rd_ok = re && (mq.size() != 0);
      wr_ok = we && ((mq.size() != c_DEPTH) || rd_ok);
      ovf_p = we && !wr_ok;
      udf_p = re && (mq.size() == 0);
    end
    if (rd_ok) sb.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(d);
    if (sc) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end
`ifdef SYNC_FIFO_STICKY_ERR_EN
    m_ovf = m_ovf | ovf_p;
    m_udf = m_udf | udf_p;
`else
    m_ovf = ovf_p;
    m_udf = udf_p;
`endif
    wr_en = we; rd_en = re; din = d; sclr_n = !sc;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; sclr_n = 1'b1;
    check_status();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"},  32'(dout),         32'h0);
    chk({tag, "_valid"}, 32'(valid),        32'h0);
    chk({tag, "_full"},  32'(full),         32'h0);
    chk({tag, "_af"},    32'(almost_full),  32'h0);
    chk({tag, "_empty"}, 32'(empty),        32'h1);
    chk({tag, "_ae"},    32'(almost_empty), 32'h1);
    chk({tag, "_ovf"},   32'(overflow),     32'h0);
    chk({tag, "_udf"},   32'(underflow),    32'h0);
    chk({tag, "_usedw"}, 32'(usedw),        32'h0);
  endtask

  initial begin
    aclr_n = 1'b0; sclr_n = 1'b1;
    din = '0; wr_en = 0; rd_en = 0;
    f_din = '0; f_wr_en = 0; f_rd_en = 0;
    m_ovf = 0; m_udf = 0;

    // Reset state
    @(posedge clk); #2;
    check_reset_outputs("reset");
    chk("f_reset_valid", 32'(f_valid), 32'h0);
    chk("f_reset_dout",  32'(f_dout),  32'h0);
    aclr_n = 1'b1;
    @(posedge clk); #1;

    // FWFT: head appears without rd_en; pop empties it
    f_wr_en = 1; f_din = 8'h3C;
    @(posedge clk); #1;
    f_wr_en = 0;
    chk("f_valid_after_wr", 32'(f_valid), 32'h1);
    chk("f_dout_after_wr",  32'(f_dout),  32'h3C);
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    chk("f_valid_after_rd", 32'(f_valid), 32'h0);
    chk("f_empty_after_rd", 32'(f_empty), 32'h1);
    // FWFT: two words, pop advances to second
    f_wr_en = 1; f_din = 8'h5A;
    @(posedge clk); #1;
    f_din = 8'h6B;
    @(posedge clk); #1;
    f_wr_en = 0;
    chk("f_dout_head1", 32'(f_dout),  32'h5A);
    chk("f_usedw2",     32'(f_usedw), 32'h2);
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    chk("f_dout_head2", 32'(f_dout),  32'h6B);
    chk("f_valid_head2", 32'(f_valid), 32'h1);

    // Fill to full with 0x11..0x15
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h11 + 8'(i), 0);
    // Write while full: rejected
    cyc(1, 0, 8'hAA, 0);
    // Write+read while full: 0x11 out, 0xBB in
    cyc(1, 1, 8'hBB, 0);
    // Drain: 0x12..0x15 then 0xBB
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 0);
    // Read while empty
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    // Synchronous clear
    cyc(0, 0, 8'h00, 1);

    // Wrap-around: prime two words, 13 concurrent pairs, drain
    cyc(1, 0, 8'h40, 0);
    cyc(1, 0, 8'h41, 0);
    for (int i = 0; i < 13; i++) cyc(1, 1, 8'h42 + 8'(i), 0);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'h60, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    // Mid-stream asynchronous clear with three words stored
    cyc(1, 0, 8'h71, 0);
    cyc(1, 0, 8'h72, 0);
    cyc(1, 0, 8'h73, 0);
    aclr_n = 1'b0;
    #2;
    check_reset_outputs("aclr");
    mq.delete(); m_ovf = 0; m_udf = 0;
    aclr_n = 1'b1;
    @(posedge clk); #1;
    check_status();

    // Synchronous clear coincident with a write: nothing stored
    cyc(1, 0, 8'h99, 1);
    cyc(0, 0, 8'h00, 0);
    // Normal operation afterwards
    cyc(1, 0, 8'h77, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
